// File: rtl/cpu_core_v2.sv
// 6502-subset multi-cycle execution core with a mem_ready wait-state handshake.
// Optional feature: define ILLEGAL_TRAP_EN to halt on unsupported opcodes.
module cpu_core_v2 #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [15:0] RESET_PC   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            din,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  sync,
   output logic [7:0]            a_out,
   output logic [7:0]            x_out,
   output logic [7:0]            y_out,
   output logic [7:0]            p_out,
   output logic [15:0]           pc_out,
   output logic [7:0]            opcode_out,
   output logic                  illegal
);

   typedef enum logic [2:0] {
      StFetch, StOp1, StOp2, StIdx, StFix, StExec, StHalt
   } state_e;

   typedef enum logic [2:0] {
      MImp, MImm, MZp, MZpx, MAbs, MAbsx
   } mode_e;

   typedef enum logic [4:0] {
      OpNop, OpLda, OpLdx, OpLdy, OpTax, OpTxa, OpTay, OpTya, OpInx, OpDex,
      OpIny, OpDey, OpAdc, OpSbc, OpAnd, OpOra, OpEor, OpSec, OpClc
   } op_e;

   typedef struct packed {
      logic  legal;
      mode_e mode;
      op_e   op;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] opc);
      dec_t d;
      d.legal = 1'b1;
      d.mode  = MImp;
      d.op    = OpNop;
      case (opc)
         8'hA9: begin d.mode = MImm;  d.op = OpLda; end
         8'hA5: begin d.mode = MZp;   d.op = OpLda; end
         8'hB5: begin d.mode = MZpx;  d.op = OpLda; end
         8'hAD: begin d.mode = MAbs;  d.op = OpLda; end
         8'hBD: begin d.mode = MAbsx; d.op = OpLda; end
         8'hA2: begin d.mode = MImm;  d.op = OpLdx; end
         8'hA0: begin d.mode = MImm;  d.op = OpLdy; end
         8'hAA: d.op = OpTax;
         8'h8A: d.op = OpTxa;
         8'hA8: d.op = OpTay;
         8'h98: d.op = OpTya;
         8'hE8: d.op = OpInx;
         8'hCA: d.op = OpDex;
         8'hC8: d.op = OpIny;
         8'h88: d.op = OpDey;
         8'h69: begin d.mode = MImm;  d.op = OpAdc; end
         8'hE9: begin d.mode = MImm;  d.op = OpSbc; end
         8'h29: begin d.mode = MImm;  d.op = OpAnd; end
         8'h09: begin d.mode = MImm;  d.op = OpOra; end
         8'h49: begin d.mode = MImm;  d.op = OpEor; end
         8'h38: d.op = OpSec;
         8'h18: d.op = OpClc;
         8'hEA: d.op = OpNop;
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   state_e      state_q, state_d;
   mode_e       mode_q, mode_d;
   op_e         op_q, op_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ea_q, ea_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
   logic        n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
   logic [15:0] addr_int;
   dec_t        dec;
   logic [8:0]  lo_sum;
   logic [8:0]  sum9;
   logic [7:0]  mm;
   logic [7:0]  res;
   logic        set_nz;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StFetch;
         mode_q   <= MImp;
         op_q     <= OpNop;
         pc_q     <= RESET_PC;
         ea_q     <= 16'h0000;
         lo_q     <= 8'h00;
         opcode_q <= 8'h00;
         a_q      <= 8'h00;
         x_q      <= 8'h00;
         y_q      <= 8'h00;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         op_q     <= op_d;
         pc_q     <= pc_d;
         ea_q     <= ea_d;
         lo_q     <= lo_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         x_q      <= x_d;
         y_q      <= y_d;
         n_q      <= n_d;
         v_q      <= v_d;
         z_q      <= z_d;
         c_q      <= c_d;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Bus address is a pure function of architectural/sequencer state, so it holds during waits.
   always_comb begin
      addr_int = pc_q;
      unique case (state_q)
         StIdx:   addr_int = {8'h00, lo_q};
         StFix:   addr_int = {ea_q[15:8] - 8'd1, ea_q[7:0]};
         StExec:  addr_int = (mode_q == MImp || mode_q == MImm) ? pc_q : ea_q;
         default: addr_int = pc_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      op_d     = op_q;
      pc_d     = pc_q;
      ea_d     = ea_q;
      lo_d     = lo_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      x_d      = x_q;
      y_d      = y_q;
      n_d      = n_q;
      v_d      = v_q;
      z_d      = z_q;
      c_d      = c_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      dec    = decode(din);
      lo_sum = {1'b0, lo_q} + {1'b0, x_q};
      mm     = (op_q == OpSbc) ? ~din : din;
      sum9   = {1'b0, a_q} + {1'b0, mm} + {8'h00, c_q};
      res    = 8'h00;
      set_nz = 1'b0;

      if (mem_ready) begin
         unique case (state_q)
            StFetch: begin
               opcode_d = din;
               pc_d     = pc_q + 16'd1;
               mode_d   = dec.mode;
               op_d     = dec.op;
               if (!dec.legal) begin
`ifdef ILLEGAL_TRAP_EN
                  state_d   = StHalt;
                  illegal_d = 1'b1;
`else
                  state_d = StExec;
`endif
               end else if (dec.mode == MImp || dec.mode == MImm) begin
                  state_d = StExec;
               end else begin
                  state_d = StOp1;
               end
            end
            StOp1: begin
               lo_d = din;
               pc_d = pc_q + 16'd1;
               ea_d = {8'h00, din};
               if (mode_q == MZp)       state_d = StExec;
               else if (mode_q == MZpx) state_d = StIdx;
               else                     state_d = StOp2;
            end
            StOp2: begin
               pc_d = pc_q + 16'd1;
               if (mode_q == MAbsx) begin
                  ea_d    = {din, lo_q} + {8'h00, x_q};
                  state_d = lo_sum[8] ? StFix : StExec;
               end else begin
                  ea_d    = {din, lo_q};
                  state_d = StExec;
               end
            end
            StIdx: begin
               ea_d    = {8'h00, lo_sum[7:0]};
               state_d = StExec;
            end
            StFix: state_d = StExec;
            StExec: begin
               state_d = StFetch;
               if (mode_q == MImm) pc_d = pc_q + 16'd1;
               unique case (op_q)
                  OpLda: begin res = din;          a_d = res; set_nz = 1'b1; end
                  OpLdx: begin res = din;          x_d = res; set_nz = 1'b1; end
                  OpLdy: begin res = din;          y_d = res; set_nz = 1'b1; end
                  OpTax: begin res = a_q;          x_d = res; set_nz = 1'b1; end
                  OpTxa: begin res = x_q;          a_d = res; set_nz = 1'b1; end
                  OpTay: begin res = a_q;          y_d = res; set_nz = 1'b1; end
                  OpTya: begin res = y_q;          a_d = res; set_nz = 1'b1; end
                  OpInx: begin res = x_q + 8'd1;   x_d = res; set_nz = 1'b1; end
                  OpDex: begin res = x_q - 8'd1;   x_d = res; set_nz = 1'b1; end
                  OpIny: begin res = y_q + 8'd1;   y_d = res; set_nz = 1'b1; end
                  OpDey: begin res = y_q - 8'd1;   y_d = res; set_nz = 1'b1; end
                  OpAnd: begin res = a_q & din;    a_d = res; set_nz = 1'b1; end
                  OpOra: begin res = a_q | din;    a_d = res; set_nz = 1'b1; end
                  OpEor: begin res = a_q ^ din;    a_d = res; set_nz = 1'b1; end
                  OpAdc, OpSbc: begin
                     // SBC reuses the adder with the operand inverted; carry out means no borrow.
                     res    = sum9[7:0];
                     a_d    = res;
                     c_d    = sum9[8];
                     v_d    = (a_q[7] == mm[7]) && (res[7] != a_q[7]);
                     set_nz = 1'b1;
                  end
                  OpSec:   c_d = 1'b1;
                  OpClc:   c_d = 1'b0;
                  default: ;
               endcase
               if (set_nz) begin
                  n_d = res[7];
                  z_d = (res == 8'h00);
               end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
         endcase
      end
   end

   assign addr       = ADDR_WIDTH'(addr_int);
   assign sync       = (state_q == StFetch);
   assign a_out      = a_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign p_out      = {n_q, v_q, 2'b11, 2'b00, z_q, c_q};
   assign pc_out     = pc_q;
   assign opcode_out = opcode_q;

endmodule

// File: tb/tb_cpu_core_v2.sv
// Directed self-checking bench for cpu_core_v2 against a flat 64 KiB memory model.
module tb_cpu_core_v2;

   logic        clk;
   logic        reset;
   logic [7:0]  din;
   logic        mem_ready;
   logic [15:0] addr;
   logic        sync;
   logic [7:0]  a_out, x_out, y_out, p_out, opcode_out;
   logic [15:0] pc_out;
   logic        illegal;

   logic [7:0]  mem [0:65535];
   int          n_checks;
   int          n_fail;

   cpu_core_v2 #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .mem_ready  (mem_ready),
      .addr       (addr),
      .sync       (sync),
      .a_out      (a_out),
      .x_out      (x_out),
      .y_out      (y_out),
      .p_out      (p_out),
      .pc_out     (pc_out),
      .opcode_out (opcode_out),
      .illegal    (illegal)
   );

   assign din = mem[addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_a"}, {8'h00, a_out}, 16'h0000);
      check_eq({tag, "_x"}, {8'h00, x_out}, 16'h0000);
      check_eq({tag, "_y"}, {8'h00, y_out}, 16'h0000);
      check_eq({tag, "_p"}, {8'h00, p_out}, 16'h0030);
      check_eq({tag, "_pc"}, pc_out, 16'h0000);
      check_eq({tag, "_addr"}, addr, 16'h0000);
      check_eq({tag, "_sync"}, {15'h0, sync}, 16'h0001);
      check_eq({tag, "_opc"}, {8'h00, opcode_out}, 16'h0000);
      check_eq({tag, "_ill"}, {15'h0, illegal}, 16'h0000);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      mem_ready = 1'b1;

      // 1: immediate load, 2 cycles
      clear_mem();
      mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'hEA;
      apply_reset();
      check_reset_state("rst");
      step(2);
      check_eq("t1_a", {8'h00, a_out}, 16'h005A);
      check_eq("t1_p", {8'h00, p_out}, 16'h0030);
      check_eq("t1_pc", pc_out, 16'h0002);
      check_eq("t1_sync", {15'h0, sync}, 16'h0001);
      check_eq("t1_opc", {8'h00, opcode_out}, 16'h00A9);

      // 2: abs,X with page cross (dummy read on unfixed page), then without
      clear_mem();
      mem[0] = 8'hA2; mem[1] = 8'hFF;
      mem[2] = 8'hBD; mem[3] = 8'hF0; mem[4] = 8'h10;
      mem[5] = 8'hBD; mem[6] = 8'h00; mem[7] = 8'h20;
      mem[16'h10EF] = 8'h33; mem[16'h11EF] = 8'h80; mem[16'h20FF] = 8'h01;
      apply_reset();
      step(2);
      check_eq("t2_x", {8'h00, x_out}, 16'h00FF);
      check_eq("t2_px", {8'h00, p_out}, 16'h00B0);
      step(3);
      check_eq("t2_fix_addr", addr, 16'h10EF);
      check_eq("t2_fix_sync", {15'h0, sync}, 16'h0000);
      step(1);
      check_eq("t2_exec_addr", addr, 16'h11EF);
      step(1);
      check_eq("t2_a", {8'h00, a_out}, 16'h0080);
      check_eq("t2_p", {8'h00, p_out}, 16'h00B0);
      check_eq("t2_pc", pc_out, 16'h0005);
      step(3);
      check_eq("t2_nocross_addr", addr, 16'h20FF);
      step(1);
      check_eq("t2_nocross_a", {8'h00, a_out}, 16'h0001);
      check_eq("t2_nocross_p", {8'h00, p_out}, 16'h0030);
      check_eq("t2_nocross_sync", {15'h0, sync}, 16'h0001);

      // 3: zp,X wraps within page zero
      clear_mem();
      mem[0] = 8'hA9; mem[1] = 8'h01; mem[2] = 8'hA2; mem[3] = 8'h10;
      mem[4] = 8'hB5; mem[5] = 8'hF8;
      mem[16'h0008] = 8'h00; mem[16'h0108] = 8'h55;
      apply_reset();
      step(4);
      check_eq("t3_a0", {8'h00, a_out}, 16'h0001);
      step(3);
      check_eq("t3_addr", addr, 16'h0008);
      step(1);
      check_eq("t3_a", {8'h00, a_out}, 16'h0000);
      check_eq("t3_p", {8'h00, p_out}, 16'h0032);
      check_eq("t3_pc", pc_out, 16'h0006);

      // 4: ADC overflow, SBC overflow with no borrow
      clear_mem();
      mem[0] = 8'h18; mem[1] = 8'hA9; mem[2] = 8'h7F; mem[3] = 8'h69; mem[4] = 8'h01;
      mem[5] = 8'h38; mem[6] = 8'hE9; mem[7] = 8'h01;
      apply_reset();
      step(6);
      check_eq("t4_adc_a", {8'h00, a_out}, 16'h0080);
      check_eq("t4_adc_p", {8'h00, p_out}, 16'h00F0);
      step(4);
      check_eq("t4_sbc_a", {8'h00, a_out}, 16'h007F);
      check_eq("t4_sbc_p", {8'h00, p_out}, 16'h0071);
      check_eq("t4_pc", pc_out, 16'h0008);

      // 5: wait states during OP2
      clear_mem();
      mem[0] = 8'hAD; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h1234] = 8'hC3;
      apply_reset();
      step(2);
      mem_ready = 1'b0;
      step(3);
      check_eq("t5_hold_addr", addr, 16'h0002);
      check_eq("t5_hold_pc", pc_out, 16'h0002);
      check_eq("t5_hold_sync", {15'h0, sync}, 16'h0000);
      mem_ready = 1'b1;
      step(1);
      check_eq("t5_exec_addr", addr, 16'h1234);
      step(1);
      check_eq("t5_a", {8'h00, a_out}, 16'h00C3);
      check_eq("t5_p", {8'h00, p_out}, 16'h00B0);
      check_eq("t5_pc", pc_out, 16'h0003);

      // 6: unsupported opcode, then reset mid-instruction
      clear_mem();
      mem[0] = 8'h02;
      apply_reset();
      step(2);
`ifdef ILLEGAL_TRAP_EN
      check_eq("t6_ill", {15'h0, illegal}, 16'h0001);
      check_eq("t6_pc", pc_out, 16'h0001);
      step(3);
      check_eq("t6_pc_hold", pc_out, 16'h0001);
      check_eq("t6_addr_hold", addr, 16'h0001);
      check_eq("t6_sync", {15'h0, sync}, 16'h0000);
`else
      check_eq("t6_ill", {15'h0, illegal}, 16'h0000);
      check_eq("t6_pc", pc_out, 16'h0001);
      check_eq("t6_sync", {15'h0, sync}, 16'h0001);
`endif
      clear_mem();
      mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'hAD; mem[3] = 8'h34; mem[4] = 8'h12;
      apply_reset();
      step(2);
      check_eq("t6_pre_a", {8'h00, a_out}, 16'h005A);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_reset_state("t6_midrst");

      // 7: transfers, inc/dec wrap (C preserved), logic ops, zero page
      clear_mem();
      mem[8'h00] = 8'h38; mem[8'h01] = 8'hA2; mem[8'h02] = 8'hFF; mem[8'h03] = 8'hE8;
      mem[8'h04] = 8'hCA; mem[8'h05] = 8'h8A; mem[8'h06] = 8'hA8; mem[8'h07] = 8'hC8;
      mem[8'h08] = 8'h88; mem[8'h09] = 8'h29; mem[8'h0A] = 8'h0F; mem[8'h0B] = 8'h09;
      mem[8'h0C] = 8'hF0; mem[8'h0D] = 8'h49; mem[8'h0E] = 8'hFF; mem[8'h0F] = 8'hA5;
      mem[8'h10] = 8'h20; mem[8'h11] = 8'hAA; mem[8'h12] = 8'hA0; mem[8'h13] = 8'h80;
      mem[8'h14] = 8'h98; mem[8'h20] = 8'h42;
      apply_reset();
      step(6);
      check_eq("t7_inx_x", {8'h00, x_out}, 16'h0000);
      check_eq("t7_inx_p", {8'h00, p_out}, 16'h0033);
      step(2);
      check_eq("t7_dex_x", {8'h00, x_out}, 16'h00FF);
      check_eq("t7_dex_p", {8'h00, p_out}, 16'h00B1);
      step(4);
      check_eq("t7_txa_a", {8'h00, a_out}, 16'h00FF);
      check_eq("t7_tay_y", {8'h00, y_out}, 16'h00FF);
      step(2);
      check_eq("t7_iny_y", {8'h00, y_out}, 16'h0000);
      check_eq("t7_iny_p", {8'h00, p_out}, 16'h0033);
      step(2);
      check_eq("t7_dey_y", {8'h00, y_out}, 16'h00FF);
      step(2);
      check_eq("t7_and_a", {8'h00, a_out}, 16'h000F);
      check_eq("t7_and_p", {8'h00, p_out}, 16'h0031);
      step(2);
      check_eq("t7_ora_a", {8'h00, a_out}, 16'h00FF);
      step(2);
      check_eq("t7_eor_a", {8'h00, a_out}, 16'h0000);
      check_eq("t7_eor_p", {8'h00, p_out}, 16'h0033);
      step(3);
      check_eq("t7_zp_a", {8'h00, a_out}, 16'h0042);
      check_eq("t7_zp_pc", pc_out, 16'h0011);
      step(2);
      check_eq("t7_tax_x", {8'h00, x_out}, 16'h0042);
      step(4);
      check_eq("t7_tya_a", {8'h00, a_out}, 16'h0080);
      check_eq("t7_tya_p", {8'h00, p_out}, 16'h00B1);
      check_eq("t7_pc", pc_out, 16'h0015);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
